// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes used by decode control and hazard logic, plus sequencer states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pipe_pkg;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_MUL  = 6'h02;
  localparam logic [5:0] OP_LDB  = 6'h10;
  localparam logic [5:0] OP_LDW  = 6'h11;
  localparam logic [5:0] OP_STB  = 6'h12;
  localparam logic [5:0] OP_STW  = 6'h13;
  localparam logic [5:0] OP_BEQ  = 6'h30;
  localparam logic [5:0] OP_JUMP = 6'h31;

  // Hazard sequencer states; encoding 2'd3 is unused and recovers to RUN.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IMISS = 2'd1,
    DMISS = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a load in EX is still producing.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is consumed by the stall sequencer in the same cycle.
// Ports: id_opcode/id_rs/id_rt describe the instruction in ID; ex_memRead/ex_rt describe
//        the load in EX; load_use is the hazard flag.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int OPC_W = 6,
  parameter int RA_W  = 5
) (
  input  logic [OPC_W-1:0] id_opcode,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             ex_memRead,
  input  logic [RA_W-1:0]  ex_rt,
  output logic             load_use
);

  logic id_uses_rt;

  // Only these formats read rt as a source; for loads and jumps rt is a
  // destination or unused, so matching it would create false stalls.
  always_comb begin
    id_uses_rt = 1'b0;
    case (id_opcode)
      OP_ADD, OP_SUB, OP_MUL, OP_STB, OP_STW, OP_BEQ: id_uses_rt = 1'b1;
      default:                                        id_uses_rt = 1'b0;
    endcase
  end

  // r0 is hardwired zero, so a load targeting it never produces a hazard.
  assign load_use = ex_memRead && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || ((ex_rt == id_rt) && id_uses_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirect, MUL occupancy, I/D misses.
// Latency: controls are combinational from state, MUL counter and inputs; state updates next clock.
// Backpressure: freezes pipeline registers (write=0) and injects NOPs (flush=1) to stall upstream.
// Ports: clk/reset; ID/EX instruction fields; memory miss/ready handshakes; per-register write
//        and flush enables; state exposes the FSM encoding.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int OPC_W   = 6,
  parameter int RA_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPC_W-1:0] id_opcode,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             ex_memRead,
  input  logic [RA_W-1:0]  ex_rt,
  input  logic             ex_is_mul,
  input  logic             ex_redirect,
  input  logic             imem_miss,
  input  logic             imem_ready,
  input  logic             dmem_miss,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic [1:0]       state
);

  localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] mul_cnt_q, mul_cnt_d;
  logic       kill_q, kill_d;
  logic       mul_stall;
  logic       load_use;

  hazard_detect #(
    .OPC_W (OPC_W),
    .RA_W  (RA_W)
  ) u_hazard_detect (
    .id_opcode  (id_opcode),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .ex_memRead (ex_memRead),
    .ex_rt      (ex_rt),
    .load_use   (load_use)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      mul_cnt_q <= 4'd0;
      kill_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
      kill_q    <= kill_d;
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    mul_stall    = 1'b0;
    state_d      = state_q;
    kill_d       = kill_q;

    case (state_q)
      RUN: begin
        if (dmem_miss) begin
          {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
          mem_wb_flush = 1'b1;
          state_d      = DMISS;
        end else if (ex_is_mul && (mul_cnt_q != MUL_LAST)) begin
          // MUL keeps EX busy: hold everything upstream, bubble into MEM.
          {pc_write, if_id_write, id_ex_write} = 3'b000;
          ex_mem_flush = 1'b1;
          mul_stall    = 1'b1;
        end else if (ex_redirect) begin
          // Wrong-path instructions in IF and ID are squashed.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          {pc_write, if_id_write} = 2'b00;
          id_ex_flush = 1'b1;
        end else if (imem_miss) begin
          {pc_write, if_id_write} = 2'b00;
          id_ex_flush = 1'b1;
          state_d     = IMISS;
        end
      end

      IMISS: begin
        if (dmem_miss) begin
          {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
          mem_wb_flush = 1'b1;
          state_d      = DMISS;
        end else begin
          {pc_write, if_id_write} = 2'b00;
          id_ex_flush = 1'b1;
          if (ex_redirect) begin
            // PC takes the target now; the fetch in flight is for the old path.
            pc_write = 1'b1;
            kill_d   = 1'b1;
          end
          if (imem_ready) begin
            if (kill_q || ex_redirect) begin
              if_id_flush = 1'b1;
            end else begin
              if_id_write = 1'b1;
            end
            kill_d  = 1'b0;
            state_d = RUN;
          end
        end
      end

      DMISS: begin
        if (dmem_ready) begin
          state_d = RUN;
        end else begin
          {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
          mem_wb_flush = 1'b1;
        end
      end

      default: begin
        {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
        state_d = RUN;
      end
    endcase

    // Pipeline is fully frozen and nothing is squashed while reset is high.
    if (reset) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
      {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = 4'b0000;
    end
  end

  // Counter restarts whenever a new instruction is allowed into EX.
  assign mul_cnt_d = mul_stall   ? mul_cnt_q + 4'd1 :
                     id_ex_write ? 4'd0 : mul_cnt_q;

  assign state = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: sequential vector table plus async-reset sequences.
// Two instances share stimulus: MUL_LAT=3 (main) and MUL_LAT=1 (never stalls on MUL).
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_memRead, ex_is_mul, ex_redirect;
  logic       imem_miss, imem_ready, dmem_miss, dmem_ready;

  logic       pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [1:0] state;
  logic       pc_write1, if_id_write1, id_ex_write1, ex_mem_write1;
  logic       if_id_flush1, id_ex_flush1, ex_mem_flush1, mem_wb_flush1;
  logic [1:0] state1;

  logic [7:0] outs0, outs1;
  assign outs0 = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
  assign outs1 = {pc_write1, if_id_write1, id_ex_write1, ex_mem_write1,
                  if_id_flush1, id_ex_flush1, ex_mem_flush1, mem_wb_flush1};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MUL_LAT(3), .OPC_W(6), .RA_W(5)) dut (
    .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_memRead(ex_memRead), .ex_rt(ex_rt), .ex_is_mul(ex_is_mul), .ex_redirect(ex_redirect),
    .imem_miss(imem_miss), .imem_ready(imem_ready), .dmem_miss(dmem_miss), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .state(state));

  pipe_hazard_ctrl #(.MUL_LAT(1), .OPC_W(6), .RA_W(5)) dut1 (
    .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_memRead(ex_memRead), .ex_rt(ex_rt), .ex_is_mul(ex_is_mul), .ex_redirect(ex_redirect),
    .imem_miss(imem_miss), .imem_ready(imem_ready), .dmem_miss(dmem_miss), .dmem_ready(dmem_ready),
    .pc_write(pc_write1), .if_id_write(if_id_write1), .id_ex_write(id_ex_write1),
    .ex_mem_write(ex_mem_write1), .if_id_flush(if_id_flush1), .id_ex_flush(id_ex_flush1),
    .ex_mem_flush(ex_mem_flush1), .mem_wb_flush(mem_wb_flush1), .state(state1));

  // Output order: pc, if_id, id_ex, ex_mem writes | if_id, id_ex, ex_mem, mem_wb flushes
  localparam logic [7:0] E_ZERO   = 8'b0000_0000;
  localparam logic [7:0] E_IDLE   = 8'b1111_0000;
  localparam logic [7:0] E_LU     = 8'b0011_0100; // load-use bubble / front-end freeze
  localparam logic [7:0] E_MULS   = 8'b0001_0010;
  localparam logic [7:0] E_RED    = 8'b1111_1100;
  localparam logic [7:0] E_DM     = 8'b0000_0001;
  localparam logic [7:0] E_IMRED  = 8'b1011_0100;
  localparam logic [7:0] E_IMKILL = 8'b0011_1100;
  localparam logic [7:0] E_IMOK   = 8'b0111_0100;

  // Control bit order: mul, redirect, imem_miss, imem_ready, dmem_miss, dmem_ready
  localparam logic [5:0] C_MUL = 6'b100000;
  localparam logic [5:0] C_RED = 6'b010000;
  localparam logic [5:0] C_IM  = 6'b001000;
  localparam logic [5:0] C_IR  = 6'b000100;
  localparam logic [5:0] C_DM  = 6'b000010;
  localparam logic [5:0] C_DR  = 6'b000001;

  typedef struct {
    logic [5:0] opc;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       mr;
    logic [4:0] ert;
    logic [5:0] ctl;
    logic [7:0] o;
    logic [1:0] st;
    logic [7:0] o1;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic addm(input logic [5:0] opc, input logic [4:0] rs, input logic [4:0] rt,
                      input logic mr, input logic [4:0] ert, input logic [5:0] ctl,
                      input logic [7:0] o, input logic [1:0] st, input logic [7:0] o1);
    vec_t v;
    v.opc = opc; v.rs = rs; v.rt = rt; v.mr = mr; v.ert = ert; v.ctl = ctl;
    v.o = o; v.st = st; v.o1 = o1;
    vecs.push_back(v);
  endtask

  task automatic add(input logic [5:0] opc, input logic [4:0] rs, input logic [4:0] rt,
                     input logic mr, input logic [4:0] ert, input logic [5:0] ctl,
                     input logic [7:0] o, input logic [1:0] st);
    addm(opc, rs, rt, mr, ert, ctl, o, st, o);
  endtask

  task automatic drive(input logic [5:0] opc, input logic [4:0] rs, input logic [4:0] rt,
                       input logic mr, input logic [4:0] ert, input logic [5:0] ctl);
    id_opcode  = opc;
    id_rs      = rs;
    id_rt      = rt;
    ex_memRead = mr;
    ex_rt      = ert;
    {ex_is_mul, ex_redirect, imem_miss, imem_ready, dmem_miss, dmem_ready} = ctl;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [7:0] o, input logic [1:0] st,
                           input logic [7:0] o1);
    check({name, " outs"}, outs0, o);
    check({name, " state"}, {6'b0, state}, {6'b0, st});
    check({name, " outs_lat1"}, outs1, o1);
  endtask

  initial begin
    // Load-use variants
    add(OP_ADD, 0, 0, 0, 0, 6'b0,      E_IDLE, 2'd0);
    add(OP_ADD, 1, 5, 1, 5, 6'b0,      E_LU,   2'd0);
    add(OP_ADD, 1, 5, 0, 0, 6'b0,      E_IDLE, 2'd0); // only one bubble
    add(OP_LDW, 3, 5, 1, 5, 6'b0,      E_IDLE, 2'd0); // LDW does not read rt
    add(OP_ADD, 0, 0, 1, 0, 6'b0,      E_IDLE, 2'd0); // r0 never hazards
    add(OP_LDW, 7, 2, 1, 7, 6'b0,      E_LU,   2'd0); // rs match
    add(OP_BEQ, 4, 9, 1, 9, 6'b0,      E_LU,   2'd0);
    add(OP_STW, 4, 9, 1, 9, 6'b0,      E_LU,   2'd0);
    add(OP_JUMP, 4, 9, 1, 9, 6'b0,     E_IDLE, 2'd0);
    add(OP_LDB, 4, 9, 1, 9, 6'b0,      E_IDLE, 2'd0);
    // Redirect overrides load-use and imem_miss
    add(OP_ADD, 1, 5, 1, 5, C_RED,     E_RED,  2'd0);
    add(OP_ADD, 0, 0, 0, 0, C_RED|C_IM, E_RED, 2'd0);
    add(OP_ADD, 0, 0, 0, 0, 6'b0,      E_IDLE, 2'd0);
    // D-miss, five cycles waiting, imem_ready ignored
    add(OP_ADD, 1, 5, 1, 5, C_DM|C_RED, E_DM,  2'd0);
    add(OP_ADD, 0, 0, 0, 0, 6'b0,      E_DM,   2'd2);
    add(OP_ADD, 0, 0, 0, 0, 6'b0,      E_DM,   2'd2);
    add(OP_ADD, 0, 0, 0, 0, C_IR,      E_DM,   2'd2);
    add(OP_ADD, 0, 0, 0, 0, 6'b0,      E_DM,   2'd2);
    add(OP_ADD, 0, 0, 0, 0, 6'b0,      E_DM,   2'd2);
    add(OP_ADD, 0, 0, 0, 0, C_DR,      E_IDLE, 2'd2);
    add(OP_ADD, 0, 0, 0, 0, 6'b0,      E_IDLE, 2'd0);
    // I-miss with redirect two cycles in, ready four cycles in
    add(OP_ADD, 0, 0, 0, 0, C_IM,      E_LU,     2'd0);
    add(OP_ADD, 0, 0, 0, 0, 6'b0,      E_LU,     2'd1);
    add(OP_ADD, 0, 0, 0, 0, C_RED,     E_IMRED,  2'd1);
    add(OP_ADD, 0, 0, 0, 0, 6'b0,      E_LU,     2'd1);
    add(OP_ADD, 0, 0, 0, 0, C_IR,      E_IMKILL, 2'd1);
    add(OP_ADD, 0, 0, 0, 0, 6'b0,      E_IDLE,   2'd0);
    // Clean I-miss: kill must have been cleared
    add(OP_ADD, 0, 0, 0, 0, C_IM,      E_LU,   2'd0);
    add(OP_ADD, 0, 0, 0, 0, C_IR,      E_IMOK, 2'd1);
    add(OP_ADD, 0, 0, 0, 0, 6'b0,      E_IDLE, 2'd0);
    // D-miss during I-miss; simultaneous ready+miss with miss persisting
    add(OP_ADD, 0, 0, 0, 0, C_IM,      E_LU,   2'd0);
    add(OP_ADD, 0, 0, 0, 0, C_DM,      E_DM,   2'd1);
    add(OP_ADD, 0, 0, 0, 0, 6'b0,      E_DM,   2'd2);
    add(OP_ADD, 0, 0, 0, 0, C_DR|C_DM, E_IDLE, 2'd2);
    add(OP_ADD, 0, 0, 0, 0, C_DM,      E_DM,   2'd0);
    add(OP_ADD, 0, 0, 0, 0, C_DR,      E_IDLE, 2'd2);
    add(OP_ADD, 0, 0, 0, 0, 6'b0,      E_IDLE, 2'd0);
    // Simultaneous ready+miss, miss drops: no extra DMISS
    add(OP_ADD, 0, 0, 0, 0, C_DM,      E_DM,   2'd0);
    add(OP_ADD, 0, 0, 0, 0, C_DR|C_DM, E_IDLE, 2'd2);
    add(OP_ADD, 0, 0, 0, 0, 6'b0,      E_IDLE, 2'd0);
    // MUL occupancy (MUL_LAT=3 vs MUL_LAT=1)
    addm(OP_ADD, 0, 0, 0, 0, C_MUL,    E_MULS, 2'd0, E_IDLE);
    addm(OP_ADD, 0, 0, 0, 0, C_MUL,    E_MULS, 2'd0, E_IDLE);
    addm(OP_ADD, 0, 0, 0, 0, C_MUL,    E_IDLE, 2'd0, E_IDLE);
    addm(OP_ADD, 0, 0, 0, 0, C_MUL,    E_MULS, 2'd0, E_IDLE); // counter restarted
    addm(OP_ADD, 0, 0, 0, 0, 6'b0,     E_IDLE, 2'd0, E_IDLE);
    addm(OP_ADD, 1, 5, 1, 5, C_MUL,    E_MULS, 2'd0, E_LU);   // MUL above load-use
    addm(OP_ADD, 0, 0, 0, 0, C_MUL,    E_MULS, 2'd0, E_IDLE);
    addm(OP_ADD, 1, 5, 1, 5, C_MUL,    E_LU,   2'd0, E_LU);
    addm(OP_ADD, 0, 0, 0, 0, 6'b0,     E_IDLE, 2'd0, E_IDLE);
    add(OP_ADD, 0, 0, 0, 0, C_MUL|C_DM, E_DM,  2'd0);         // D-miss above MUL
    add(OP_ADD, 0, 0, 0, 0, C_DR,      E_IDLE, 2'd2);
    add(OP_ADD, 0, 0, 0, 0, 6'b0,      E_IDLE, 2'd0);

    reset = 1'b1;
    drive(OP_ADD, 0, 0, 0, 0, 6'b0);
    #1;
    check_all("reset", E_ZERO, 2'd0, E_ZERO);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].opc, vecs[i].rs, vecs[i].rt, vecs[i].mr, vecs[i].ert, vecs[i].ctl);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].o, vecs[i].st, vecs[i].o1);
    end

    // Asynchronous reset in the middle of a D-miss
    @(negedge clk);
    drive(OP_ADD, 0, 0, 0, 0, C_DM);
    #1 check_all("dm_enter", E_DM, 2'd0, E_DM);
    @(negedge clk);
    drive(OP_ADD, 0, 0, 0, 0, 6'b0);
    #1 check_all("dm_wait", E_DM, 2'd2, E_DM);
    #2 reset = 1'b1;
    #1 check_all("dm_async_rst", E_ZERO, 2'd0, E_ZERO);
    @(negedge clk);
    reset = 1'b0;
    #1 check_all("dm_post_rst", E_IDLE, 2'd0, E_IDLE);
    @(negedge clk);
    #1 check_all("dm_post_rst2", E_IDLE, 2'd0, E_IDLE);

    // Asynchronous reset after two MUL stall cycles must restart the count
    @(negedge clk);
    drive(OP_ADD, 0, 0, 0, 0, C_MUL);
    #1 check_all("mul_s0", E_MULS, 2'd0, E_IDLE);
    @(negedge clk);
    #1 check_all("mul_s1", E_MULS, 2'd0, E_IDLE);
    #2 reset = 1'b1;
    #1 check_all("mul_async_rst", E_ZERO, 2'd0, E_ZERO);
    @(negedge clk);
    reset = 1'b0;
    #1 check_all("mul_post_rst", E_MULS, 2'd0, E_IDLE);
    @(negedge clk);
    drive(OP_ADD, 0, 0, 0, 0, 6'b0);
    #1 check_all("mul_idle", E_IDLE, 2'd0, E_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Resolves load-use hazards, taken-branch/jump redirects, multi-cycle MUL occupancy of EX, and instruction/data memory misses.
- Drives the write-enable and bubble-insert controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Sits beside the decode control unit and replaces its ad-hoc control-bit flush.

Parameters:
- MUL_LAT, 3: total cycles a MUL occupies EX; legal range 1..15.
- OPC_W, 6: opcode width.
- RA_W, 5: register-address width.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- id_opcode  in  OPC_W  opcode of the instruction in ID (instruction[31:26])
- id_rs  in  RA_W  rs field of the instruction in ID
- id_rt  in  RA_W  rt field of the instruction in ID
- ex_memRead  in  1  instruction in EX is LDB/LDW
- ex_rt  in  RA_W  destination register of the load in EX
- ex_is_mul  in  1  instruction in EX is MUL
- ex_redirect  in  1  taken BEQ or JUMP resolved in EX this cycle
- imem_miss  in  1  instruction fetch missed this cycle
- imem_ready  in  1  pending instruction fetch completes this cycle
- dmem_miss  in  1  access in MEM missed this cycle
- dmem_ready  in  1  pending data access completes this cycle
- pc_write  out  1  PC register enable
- if_id_write  out  1  IF/ID enable
- id_ex_write  out  1  ID/EX enable
- ex_mem_write  out  1  EX/MEM enable
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_flush  out  1  load NOP (all control bits 0) into ID/EX
- ex_mem_flush  out  1  load NOP into EX/MEM
- mem_wb_flush  out  1  load NOP into MEM/WB
- state  out  2  FSM state (debug/verification visibility)

Behaviour:
- Clocking and reset: one clock domain, clk. reset is asynchronous and active-high.
- While reset is asserted:
  - state = RUN (2'd0), mul_cnt = 0, kill_pending = 0.
  - All *_write = 0, all *_flush = 0.
- Outputs are combinational from state, the counters and the inputs.
- With no hazard present: all *_write = 1, all *_flush = 0.
- FSM states: RUN = 0, IMISS = 1, DMISS = 2. Encoding 3 is illegal and returns to RUN on the next clock.
- Priority in RUN, highest first; only the highest active rule applies:
  1. dmem_miss: all four *_write = 0, mem_wb_flush = 1; next state = DMISS.
  2. MUL stall: active when ex_is_mul and mul_cnt != MUL_LAT-1.
     - pc_write, if_id_write, id_ex_write = 0; ex_mem_flush = 1.
     - mul_cnt increments.
     - mul_cnt clears whenever id_ex_write = 1.
     - MUL_LAT = 1 never stalls.
  3. ex_redirect: pc_write = 1, if_id_flush = 1, id_ex_flush = 1. Overrides load-use and imem_miss.
  4. Load-use: active when ex_memRead, ex_rt != 0, and either ex_rt == id_rs or (ex_rt == id_rt and id_uses_rt).
     - pc_write = 0, if_id_write = 0, id_ex_flush = 1. Exactly one bubble.
  5. imem_miss: pc_write = 0, if_id_write = 0, id_ex_flush = 1; next state = IMISS.
- id_uses_rt = 1 for ADD (0x00), SUB (0x01), MUL (0x02), STB (0x12), STW (0x13) and BEQ (0x30); 0 for every other opcode.
- IMISS:
  - Front end frozen: pc_write = 0, if_id_write = 0, id_ex_flush = 1. The back end keeps running.
  - ex_redirect during IMISS: pc_write = 1 that cycle and kill_pending is set.
  - On imem_ready: if kill_pending, if_id_flush = 1 and if_id_write = 0 (stale fetch discarded); otherwise if_id_write = 1. Then kill_pending clears and next state = RUN.
  - dmem_miss during IMISS: next state = DMISS with kill_pending retained. The fetch is re-requested from RUN afterwards.
- DMISS:
  - All *_write = 0, mem_wb_flush = 1, until dmem_ready.
  - On dmem_ready: next state = RUN, and outputs that cycle are as in RUN with no hazard.
  - imem_ready arriving during DMISS is ignored by this block.
- Simultaneous dmem_ready and dmem_miss in DMISS: ready wins and the FSM stays in DMISS for one extra cycle only if dmem_miss is still high in the following RUN cycle.
- Reset mid-miss or mid-MUL: returns to RUN immediately, counters cleared, no flush is issued.

Decomposition:
- Shared package pipe_pkg holds:
  - the opcode constants (OP_ADD 0x00, OP_SUB 0x01, OP_MUL 0x02, OP_LDB 0x10, OP_LDW 0x11, OP_STB 0x12, OP_STW 0x13, OP_BEQ 0x30, OP_JUMP 0x31), shared with decode control;
  - the state encodings RUN/IMISS/DMISS.
- One sub-module, hazard_detect: the purely combinational load-use comparator including id_uses_rt decode.

Test Plan:
- Load-use: ex_memRead=1, ex_rt=5, id_opcode=ADD, id_rt=5 -> exactly one cycle of pc_write=0, if_id_write=0, id_ex_flush=1. Repeat with id_opcode=LDW, id_rt=5, id_rs=3 -> no stall. Repeat with ex_rt=0 -> no stall.
- MUL, MUL_LAT=3: ex_is_mul held -> 2 stall cycles with ex_mem_flush=1, third cycle all writes 1, mul_cnt back to 0. With MUL_LAT=1 -> zero stall cycles.
- Redirect with load-use in the same cycle: ex_redirect=1 -> pc_write=1, if_id_flush=1, id_ex_flush=1; load-use is ignored.
- IMISS with redirect: imem_miss, then ex_redirect 2 cycles later, imem_ready 4 cycles later -> pc_write=1 only on the redirect cycle; on ready if_id_flush=1, state RUN next cycle.
- DMISS: dmem_miss, then dmem_ready after 5 cycles -> 5 cycles of all writes 0 with mem_wb_flush=1, state=2; then RUN. A dmem_miss during IMISS goes to DMISS.
- Reset asserted asynchronously mid-DMISS -> state=0, all outputs 0 the same instant; after release, idle outputs are all writes 1, flushes 0.
